lfsr: RTL and testbench
=======================

// Module: lfsr
//
// PURPOSE
//   Free-running maximal-length Fibonacci LFSR used as the pseudo-random source
//   for the game logic (piece selection and similar). Default build: 15-bit state,
//   polynomial x^15 + x^14 + 1, period 2^15-1 = 32767. The full state is the output.
//   It advances once per clock whenever out of reset; no enable and no load port.
//
// PARAMETERS
//   WIDTH  15        state/output width; legal range 2..32 (elaboration error otherwise)
//   SEED   'h0001    reset/recovery state, WIDTH bits; must be nonzero (elab check)
//   TAPS   '0        tap mask (bit i set = state[i] feeds XOR); '0 selects lfsr_pkg default
//
// PORTS
//   clk     in   1      single clock; state updates on rising edge
//   nreset  in   1      asynchronous, active-low reset
//   out     out  WIDTH  current LFSR state
//
// BEHAVIOUR
//   - Reset: nreset low -> out = SEED immediately (async), held while low.
//   - Release: synchronous to clk. The first update happens on the first rising
//     edge that sees nreset high. State before the first reset is undefined (X in simulation).
//   - Step, every rising edge with nreset high:
//       fb   = ^(out & TAPS_EFF)
//       out <= {out[WIDTH-2:0], fb}     (shift toward MSB, feedback into bit 0)
//   - TAPS_EFF = (TAPS != 0) ? TAPS : lfsr_pkg::max_taps(WIDTH).
//     For WIDTH=15, TAPS_EFF = 15'h6000, i.e. bits 14 and 13.
//   - Lock-up guard: if out == 0 (for example after an upset), the next state is SEED, not 0.
//   - Latency: the output is the register itself. There is no combinational path from
//     any input to out, other than the async reset.
//   - Reset mid-sequence: out returns to SEED at once. The sequence restarts from
//     step 0 after release.
//   - Sequence from SEED=1, WIDTH=15, value after n clocks:
//     n=0 -> 0x0001, n=1 -> 0x0002, ... n=13 -> 0x2000, n=14 -> 0x4001, n=15 -> 0x0003.
//     Out of reset, the state is never 0.
//
// STRUCTURE
//   - Package lfsr_pkg holds:
//       - function max_taps(int w) -> logic [31:0]: a maximal-length tap table for
//         widths 2..32 (Xilinx XAPP052 set, expressed as two-/four-tap XNOR-free masks).
//       - localparam LFSR_MIN_W = 2 and LFSR_MAX_W = 32.
//   - One module, no sub-module. It contains:
//       - the tap-mask derivation;
//       - elaboration-time assertions on WIDTH, SEED and TAPS;
//       - the next-state function;
//       - the single state register.
//   - Optional simulation-only assertions (translate_off): out is never 0 while
//     nreset has been high for at least one edge.
//
// TESTING
//   - Reset: nreset=0 at any clock phase -> out == 0x0001 within 0 time; held over
//     5 edges while nreset stays low.
//   - Shift: release reset, then 14 edges -> out == 0x0002, 0x0004, ..., 0x2000, 0x4001.
//     Edge 15 -> out == 0x0003.
//   - Period: run 32767 edges from SEED -> out == 0x0001 again, and not earlier.
//     Every nonzero 15-bit value appears exactly once; 0 never appears.
//   - Mid-run reset: pulse nreset low for 5 ns between edges after 100 steps ->
//     out == 0x0001 during the pulse. After release the sequence repeats the values
//     listed in Shift.
//   - Lock-up: force the state to 0, release the force, one edge -> out == SEED.
//   - Parameter sweep: WIDTH in {2,4,8,16,32} with default taps -> measured period is
//     2^WIDTH-1. SEED=0 fails elaboration.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length tap table for the LFSR.
// Masks use bit i = state[i], so tap n of the classic 1-based tables sits at bit n-1.
package lfsr_pkg;

  localparam int LFSR_MIN_W = 2;
  localparam int LFSR_MAX_W = 32;

  function automatic logic [31:0] max_taps(input int w);
    logic [31:0] m;
    m = '0;
    case (w)
      2:  m = 32'h0000_0003;
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_if.sv
// Carries the LFSR state to its consumers; the generator drives, game logic reads.
interface lfsr_if #(
  parameter int WIDTH = 15
);
  logic [WIDTH-1:0] out;

  modport master (output out);
  modport slave  (input  out);
endinterface

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR: shifts toward the MSB, XOR feedback into bit 0,
// and recovers to SEED if the state is ever found at zero.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic             clk,
  input  logic             nreset,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] TAPS_EFF = (TAPS != '0) ? TAPS : WIDTH'(max_taps(WIDTH));

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr: WIDTH %0d outside supported range", WIDTH);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be nonzero");
  end
  // Without the top bit in the mask the register is not a WIDTH-bit LFSR at all.
  if (TAPS_EFF[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr: tap mask must include bit WIDTH-1");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] nxt;
  logic             fb;

  always_comb begin
    fb  = ^(state & TAPS_EFF);
    nxt = {state[WIDTH-2:0], fb};
    // Zero is a fixed point of XOR feedback; kick it back onto the sequence.
    if (state == '0) nxt = SEED;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= SEED;
    else         state <= nxt;
  end

  assign out = state;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: reset, shift sequence, full period, mid-run reset,
// lock-up recovery and short width sweep.
module tb_lfsr;

  logic clk;
  logic nreset;

  lfsr_if #(.WIDTH(15)) rng ();

  logic [1:0]  o2;
  logic [3:0]  o4;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [31:0] o32;

  lfsr #(.WIDTH(15)) u_dut (.clk(clk), .nreset(nreset), .out(rng.out));
  lfsr #(.WIDTH(2))  u_w2  (.clk(clk), .nreset(nreset), .out(o2));
  lfsr #(.WIDTH(4))  u_w4  (.clk(clk), .nreset(nreset), .out(o4));
  lfsr #(.WIDTH(8))  u_w8  (.clk(clk), .nreset(nreset), .out(o8));
  lfsr #(.WIDTH(16)) u_w16 (.clk(clk), .nreset(nreset), .out(o16));
  lfsr #(.WIDTH(32)) u_w32 (.clk(clk), .nreset(nreset), .out(o32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Hand-derived 15-bit sequence from SEED=1 for steps 1..15.
  function automatic logic [31:0] shift_exp(input int n);
    logic [31:0] v;
    if (n <= 13)       v = 32'h1 << n;
    else if (n == 14)  v = 32'h4001;
    else               v = 32'h0003;
    return v;
  endfunction

  bit seen [0:32767];
  logic [31:0] w16_exp [1:5];
  logic [31:0] w32_exp [1:3];

  initial begin
    int dup, first_ret, p2, p4, p8;
    w16_exp = '{32'h2, 32'h4, 32'h8, 32'h11, 32'h22};
    w32_exp = '{32'h3, 32'h6, 32'hD};
    foreach (seen[i]) seen[i] = 1'b0;
    dup = 0; first_ret = 0; p2 = 0; p4 = 0; p8 = 0;

    // Async reset asserted mid-phase, then held across several edges.
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1 chk("rst_async", 32'(rng.out), 32'h1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_hold", 32'(rng.out), 32'h1);
    end

    @(negedge clk) nreset = 1'b1;
    seen[1] = 1'b1;
    for (int n = 1; n <= 32767; n++) begin
      @(posedge clk); #1;
      if (n <= 15) chk($sformatf("shift_%0d", n), 32'(rng.out), shift_exp(n));
      if (n <= 5)  chk($sformatf("w16_%0d", n), 32'(o16), w16_exp[n]);
      if (n <= 3)  chk($sformatf("w32_%0d", n), o32, w32_exp[n]);
      if (p2 == 0 && o2 == 2'd1) p2 = n;
      if (p4 == 0 && o4 == 4'd1) p4 = n;
      if (p8 == 0 && o8 == 8'd1) p8 = n;
      if (first_ret == 0 && rng.out == 15'h1) first_ret = n;
      if (n < 32767) begin
        if (seen[rng.out]) dup++;
        seen[rng.out] = 1'b1;
      end
    end
    chk("period", 32'(first_ret), 32'd32767);
    chk("dup_vals", 32'(dup), 32'd0);
    chk("zero_seen", 32'(seen[0]), 32'd0);
    chk("period_w2", 32'(p2), 32'd3);
    chk("period_w4", 32'(p4), 32'd15);
    chk("period_w8", 32'(p8), 32'd255);

    // 5 ns low pulse placed entirely between two rising edges.
    repeat (100) @(posedge clk);
    @(posedge clk); #2 nreset = 1'b0;
    #1 chk("mid_rst", 32'(rng.out), 32'h1);
    #4 nreset = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_shift_%0d", n), 32'(rng.out), shift_exp(n));
    end

    // Zero state recovers to SEED on the next edge.
    @(negedge clk);
    force u_dut.state = '0;
    #1 release u_dut.state;
    #1 chk("lock_zero", 32'(rng.out), 32'h0);
    @(posedge clk); #1;
    chk("lock_recover", 32'(rng.out), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
